// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//
// SPI bus master, mode 0 (CPOL=0, CPHA=0), MSB first. Drives SCK, SSEL and
// MOSI and samples MISO. Words are exchanged over a valid/ready interface. The
// per-word tx_last flag decides whether SSEL is released after the word or
// kept low so the next word continues the same message.
//
// Parameters
//   WIDTH        bits per word (>= 2)
//   HALF_PERIOD  clk cycles per SCK half-period (>= 1, >= 4 for our slave)
//
// Ports
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   tx_data   in   word to send, sampled on accept
//   tx_valid  in   tx_data / tx_last valid
//   tx_last   in   release SSEL after this word
//   tx_ready  out  word accepted when tx_valid && tx_ready
//   rx_data   out  last received word, held until the next rx_valid
//   rx_valid  out  one-cycle pulse, rx_data updated
//   busy      out  high whenever the master is not idle
//   SCK       out  serial clock, idles low
//   SSEL      out  slave select, active low
//   MOSI      out  serial data out
//   MISO      in   serial data in
// ---------------------------------------------------------------------------
module spi_master #(
   parameter int WIDTH       = 8,
   parameter int HALF_PERIOD = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   input  logic             tx_last,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             SCK,
   output logic             SSEL,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [CW-1:0] HP_LAST   = CW'(HALF_PERIOD - 1);
   // When a continuation word is accepted in WORD_END, that cycle already
   // counts as the first cycle of the SCK low phase, so the LEAD wait starts
   // one count in. This keeps every low phase exactly HALF_PERIOD cycles and
   // makes back-to-back words exactly 2*WIDTH*HALF_PERIOD cycles apart. With
   // HALF_PERIOD=1 there is nothing to shorten, so LEAD waits its full cycle.
   localparam logic [CW-1:0] HP_RESUME = (HALF_PERIOD > 1) ? CW'(1) : CW'(0);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LEAD     = 3'd1;
   localparam logic [2:0] ST_HIGH     = 3'd2;
   localparam logic [2:0] ST_LOW      = 3'd3;
   localparam logic [2:0] ST_WORD_END = 3'd4;
   localparam logic [2:0] ST_TRAIL    = 3'd5;
   localparam logic [2:0] ST_GUARD    = 3'd6;

   logic [2:0]       state_q,     state_d;
   logic [CW-1:0]    hp_cnt_q,    hp_cnt_d;
   logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
   logic [WIDTH-1:0] tx_sr_q,     tx_sr_d;
   logic [WIDTH-1:0] rx_sr_q,     rx_sr_d;
   logic             last_q,      last_d;
   logic [WIDTH-1:0] rx_data_q,   rx_data_d;
   logic             rx_valid_q,  rx_valid_d;
   logic             sck_q,       sck_d;
   logic             ssel_q,      ssel_d;
   logic             mosi_q,      mosi_d;

   logic             hp_done;
   logic             accept;

   // Handshake: a word can be taken when idle, or between words of a
   // message that has not yet seen its last word. Forced low during reset.
   always_comb begin
      tx_ready = resetn &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_WORD_END) && !last_q));
   end

   assign accept  = tx_valid && tx_ready;
   assign hp_done = (hp_cnt_q == HP_LAST);

   // Next-state and datapath logic. All bus outputs are registered so that
   // SCK, SSEL and MOSI change only on clk edges and never glitch.
   always_comb begin
      state_d    = state_q;
      hp_cnt_d   = hp_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      last_d     = last_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sck_d      = sck_q;
      ssel_d     = ssel_q;
      mosi_d     = mosi_q;

      case (state_q)
         ST_IDLE: begin
            sck_d  = 1'b0;
            ssel_d = 1'b1;
            if (accept) begin
               tx_sr_d   = tx_data;
               last_d    = tx_last;
               ssel_d    = 1'b0;
               mosi_d    = tx_data[WIDTH-1];
               bit_cnt_d = '0;
               hp_cnt_d  = '0;
               state_d   = ST_LEAD;
            end
         end

         // LEAD and LOW both end in a rising SCK edge with MISO captured on
         // that same clk edge.
         ST_LEAD, ST_LOW: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               sck_d    = 1'b1;
               rx_sr_d  = {rx_sr_q[WIDTH-2:0], MISO};
               state_d  = ST_HIGH;
            end else begin
               hp_cnt_d = hp_cnt_q + CW'(1);
            end
         end

         ST_HIGH: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               sck_d    = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  rx_data_d  = rx_sr_q;
                  rx_valid_d = 1'b1;
                  // A last word's WORD_END pass is merged into TRAIL: both
                  // hold SCK low, SSEL low and tx_ready low, and merging
                  // puts the SSEL rise exactly one half-period after the
                  // final falling edge.
                  state_d    = last_q ? ST_TRAIL : ST_WORD_END;
               end else begin
                  tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
                  mosi_d    = tx_sr_q[WIDTH-2];
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  state_d   = ST_LOW;
               end
            end else begin
               hp_cnt_d = hp_cnt_q + CW'(1);
            end
         end

         // Waits indefinitely for the next word of the message; SSEL stays
         // low and MOSI keeps the last bit sent.
         ST_WORD_END: begin
            sck_d = 1'b0;
            if (accept) begin
               tx_sr_d   = tx_data;
               last_d    = tx_last;
               mosi_d    = tx_data[WIDTH-1];
               bit_cnt_d = '0;
               hp_cnt_d  = HP_RESUME;
               state_d   = ST_LEAD;
            end
         end

         ST_TRAIL: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               ssel_d   = 1'b1;
               state_d  = ST_GUARD;
            end else begin
               hp_cnt_d = hp_cnt_q + CW'(1);
            end
         end

         // Minimum SSEL-high time before another message may start.
         ST_GUARD: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               state_d  = ST_IDLE;
            end else begin
               hp_cnt_d = hp_cnt_q + CW'(1);
            end
         end

         default: begin
            hp_cnt_d = '0;
            sck_d    = 1'b0;
            ssel_d   = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset drops the bus to idle immediately and discards
   // any partially received word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         hp_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         last_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sck_q      <= 1'b0;
         ssel_q     <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hp_cnt_q   <= hp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         last_q     <= last_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sck_q      <= sck_d;
         ssel_q     <= ssel_d;
         mosi_q     <= mosi_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q != ST_IDLE);
   assign SCK      = sck_q;
   assign SSEL     = ssel_q;
   assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
//
// Self-checking bench for spi_master. A default instance (WIDTH=8,
// HALF_PERIOD=4) talks either to a MOSI->MISO loopback or to a behavioural
// mode-0 slave; a second instance (WIDTH=16, HALF_PERIOD=1) runs in loopback.
// Stimulus pushes expected words and bus timings into queues; independent
// monitor processes pop and compare whenever the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_spi_master;

   localparam int W   = 8;
   localparam int H   = 4;
   localparam int W16 = 16;
   localparam int H16 = 1;

   logic          clk = 1'b0;
   logic          resetn;

   logic [W-1:0]  tx_data;
   logic          tx_valid;
   logic          tx_last;
   logic          tx_ready;
   logic [W-1:0]  rx_data;
   logic          rx_valid;
   logic          busy;
   logic          SCK;
   logic          SSEL;
   logic          MOSI;
   logic          MISO;

   logic          loop_mode;
   logic          miso_slave;

   logic [W16-1:0] d16;
   logic           v16;
   logic           last16;
   logic           ready16;
   logic [W16-1:0] rxd16;
   logic           rxv16;
   logic           busy16;
   logic           sck16;
   logic           ssel16;
   logic           mosi16;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] slave_resp[$];
   logic [W-1:0] exp_rx[$];
   logic [W-1:0] exp_mosi[$];
   int           exp_ssel_len[$];
   int           exp_rises[$];
   logic [W-1:0] msg_tx[$];
   logic [W-1:0] msg_rs[$];

   assign MISO = loop_mode ? MOSI : miso_slave;

   always #5 clk = ~clk;

   spi_master #(.WIDTH(W), .HALF_PERIOD(H)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .SCK      (SCK),
      .SSEL     (SSEL),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   spi_master #(.WIDTH(W16), .HALF_PERIOD(H16)) dut16 (
      .clk      (clk),
      .resetn   (resetn),
      .tx_data  (d16),
      .tx_valid (v16),
      .tx_last  (last16),
      .tx_ready (ready16),
      .rx_data  (rxd16),
      .rx_valid (rxv16),
      .busy     (busy16),
      .SCK      (sck16),
      .SSEL     (ssel16),
      .MOSI     (mosi16),
      .MISO     (mosi16)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   function automatic logic [W-1:0] peek_resp();
      return (slave_resp.size() > 0) ? slave_resp[0] : '0;
   endfunction

   // Behavioural mode-0 slave: presents its MSB when selected, captures MOSI
   // on SCK rise, moves to the next bit on SCK fall.
   initial begin : slave_model
      logic [W-1:0] word;
      logic [W-1:0] cap;
      int           bits;
      miso_slave = 1'b0;
      cap        = '0;
      forever begin
         @(negedge SSEL);
         bits       = 0;
         word       = peek_resp();
         miso_slave = word[W-1];
         while (SSEL === 1'b0 && resetn) begin
            @(posedge SCK or posedge SSEL);
            if (SSEL !== 1'b0 || !resetn) break;
            if (bits == 0 && slave_resp.size() > 0) void'(slave_resp.pop_front());
            cap = {cap[W-2:0], MOSI};
            bits++;
            @(negedge SCK or posedge SSEL);
            if (SSEL !== 1'b0 || !resetn) break;
            if (bits == W) begin
               if (exp_mosi.size() == 0)
                  report_fail("mosi_word", $sformatf("unexpected word 0x%0h, none required", cap));
               else
                  check_output("mosi_word", cap, exp_mosi.pop_front());
               bits = 0;
               word = peek_resp();
            end else begin
               word = word << 1;
            end
            miso_slave = word[W-1];
         end
      end
   end

   int   cyc = 0;
   int   last_rx = -1;
   int   ssel_len, rises, high_len, low_len;
   logic prev_sck, prev_ssel, prev_mosi;

   // Monitor: received words, SCK phase widths, MOSI stability while SCK is
   // high, SSEL-low length, SCK pulse count and word spacing.
   always @(negedge clk) begin
      cyc++;
      if (!resetn) begin
         ssel_len  = 0;
         rises     = 0;
         high_len  = 0;
         low_len   = 0;
         last_rx   = -1;
         prev_sck  = 1'b0;
         prev_ssel = 1'b1;
         prev_mosi = 1'b0;
      end else begin
         if (rx_valid) begin
            if (exp_rx.size() == 0)
               report_fail("rx_word", $sformatf("unexpected rx_valid with 0x%0h, none required", rx_data));
            else
               check_output("rx_word", rx_data, exp_rx.pop_front());
            if (last_rx >= 0) check_output("rx_spacing", cyc - last_rx, 2 * W * H);
            last_rx = cyc;
         end
         if (SCK && !prev_sck) begin
            rises++;
            check_output("sck_low_width", low_len, H);
            low_len = 0;
         end
         if (!SCK && prev_sck) begin
            check_output("sck_high_width", high_len, H);
            high_len = 0;
         end
         if (SCK && prev_sck) check_output("mosi_stable_high", MOSI, prev_mosi);
         if (SCK) high_len++;
         if (!SCK && !SSEL) low_len++;
         if (!SSEL) ssel_len++;
         if (SSEL && !prev_ssel) begin
            if (exp_ssel_len.size() == 0) begin
               report_fail("ssel_window", "unexpected SSEL rise");
            end else begin
               check_output("ssel_low_len", ssel_len, exp_ssel_len.pop_front());
               check_output("sck_pulses", rises, exp_rises.pop_front());
            end
            ssel_len = 0;
            rises    = 0;
            low_len  = 0;
            last_rx  = -1;
         end
         prev_sck  = SCK;
         prev_ssel = SSEL;
         prev_mosi = MOSI;
      end
   end

   task automatic wait_sck_edges(input bit rising, input int n);
      int   seen  = 0;
      int   guard = 0;
      logic prev  = SCK;
      while (seen < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (rising ? (SCK && !prev) : (!SCK && prev)) seen++;
         prev = SCK;
      end
      if (seen < n) report_fail("sck_edge_wait", $sformatf("saw %0d edges, required %0d", seen, n));
   endtask

   // Sends msg_tx as one message with tx_valid held, recording the
   // expected received words, MOSI words and bus timings first.
   task automatic apply_stimulus(input bit slave_mode);
      int n = msg_tx.size();
      int guard;
      loop_mode = !slave_mode;
      for (int i = 0; i < n; i++) begin
         if (slave_mode) begin
            slave_resp.push_back(msg_rs[i]);
            exp_rx.push_back(msg_rs[i]);
         end else begin
            exp_rx.push_back(msg_tx[i]);
         end
         exp_mosi.push_back(msg_tx[i]);
      end
      exp_ssel_len.push_back(n * 2 * W * H + H);
      exp_rises.push_back(n * W);
      @(negedge clk);
      tx_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         tx_data = msg_tx[i];
         tx_last = (i == n - 1);
         guard = 0;
         while (!tx_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         if (!tx_ready) begin
            report_fail("accept_wait", "tx_ready never rose");
            break;
         end
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy && guard < 2000);
      if (busy) report_fail("idle_wait", "busy never fell");
      repeat ($urandom_range(1, 5)) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_ssel"},     SSEL,     1'b1);
      check_output({tag, "_sck"},      SCK,      1'b0);
      check_output({tag, "_mosi"},     MOSI,     1'b0);
      check_output({tag, "_busy"},     busy,     1'b0);
      check_output({tag, "_tx_ready"}, tx_ready, 1'b0);
      check_output({tag, "_rx_valid"}, rx_valid, 1'b0);
      check_output({tag, "_rx_data"},  rx_data,  '0);
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: actual=time limit reached required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [W16-1:0] w16;
      int             k;
      tx_valid  = 1'b0;
      tx_last   = 1'b0;
      tx_data   = '0;
      v16       = 1'b0;
      last16    = 1'b0;
      d16       = '0;
      loop_mode = 1'b1;
      resetn    = 1'b1;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check_output("idle_tx_ready", tx_ready, 1'b1);

      $display("[TB] loopback 0xA5");
      msg_tx = '{8'hA5};
      apply_stimulus(1'b0);

      $display("[TB] slave model 0xC3 / 0x3C");
      msg_tx = '{8'hC3};
      msg_rs = '{8'h3C};
      apply_stimulus(1'b1);

      $display("[TB] three-word message");
      msg_tx = '{8'h01, 8'h80, 8'hFF};
      apply_stimulus(1'b0);

      $display("[TB] tx_valid during transfer");
      msg_tx = '{8'h96};
      fork
         apply_stimulus(1'b0);
         begin
            wait_sck_edges(1'b0, 2);
            tx_data  = 8'h55;
            tx_last  = 1'b1;
            tx_valid = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check_output("busy_tx_ready", tx_ready, 1'b0);
               check_output("busy_flag", busy, 1'b1);
            end
            tx_valid = 1'b0;
         end
      join

      $display("[TB] reset mid-word");
      loop_mode = 1'b1;
      @(negedge clk);
      tx_data  = 8'h69;
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      wait_sck_edges(1'b1, 4);
      resetn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      msg_tx = '{8'h5A};
      apply_stimulus(1'b0);

      $display("[TB] random messages");
      for (int m = 0; m < 8; m++) begin
         int  n;
         bit  sm;
         n  = $urandom_range(1, 3);
         sm = 1'($urandom_range(0, 1));
         msg_tx.delete();
         msg_rs.delete();
         for (int i = 0; i < n; i++) begin
            msg_tx.push_back(W'($urandom));
            msg_rs.push_back(W'($urandom));
         end
         apply_stimulus(sm);
      end

      $display("[TB] WIDTH=16 HALF_PERIOD=1 loopback");
      for (int i = 0; i < 3; i++) begin
         w16 = (i == 0) ? 16'hBEEF : 16'($urandom);
         @(negedge clk);
         check_output("w16_tx_ready", ready16, 1'b1);
         d16    = w16;
         last16 = 1'b1;
         v16    = 1'b1;
         @(posedge clk);
         #1 v16 = 1'b0;
         k = 0;
         while (k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (rxv16) break;
         end
         check_output("w16_latency", k, 2 * W16 * H16);
         check_output("w16_rx_word", rxd16, w16);
         k = 0;
         while (busy16 && k < 200) begin
            @(negedge clk);
            k++;
         end
         check_output("w16_idle", busy16, 1'b0);
         check_output("w16_ssel_idle", ssel16, 1'b1);
         check_output("w16_sck_idle", sck16, 1'b0);
      end

      repeat (5) @(negedge clk);
      check_output("rx_queue_drained", exp_rx.size(), 0);
      check_output("mosi_queue_drained", exp_mosi.size(), 0);
      check_output("ssel_queue_drained", exp_ssel_len.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

SPI bus master (mode 0: CPOL=0, CPHA=0, MSB first) that drives SCK, SSEL and MOSI and samples MISO. It is the initiator side for our SPI slave: it generates the bus waveforms that slave expects, at a rate that slave's 3-stage input synchronisers can follow. The system side sees a valid/ready word interface. A per-word `tx_last` flag keeps SSEL asserted across multi-word messages.

## Interface
- `WIDTH`, 8: bits per word.
- `HALF_PERIOD`, 4: clk cycles per SCK half-period, ≥1. Must be ≥4 when talking to our slave.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `tx_data`  in  WIDTH  word to send.
- `tx_valid`  in  1  tx_data/tx_last valid.
- `tx_last`  in  1  deassert SSEL after this word.
- `tx_ready`  out  1  word accepted on a cycle with tx_valid && tx_ready.
- `rx_data`  out  WIDTH  last received word; held until next rx_valid.
- `rx_valid`  out  1  one-cycle pulse, rx_data updated.
- `busy`  out  1  high whenever state ≠ IDLE.
- `SCK`  out  1  serial clock, idles low.
- `SSEL`  out  1  slave select, active low.
- `MOSI`  out  1  serial data out.
- `MISO`  in  1  serial data in.

## Operation
- Datapath: tx shift register (WIDTH), rx shift register (WIDTH), bit counter ($clog2(WIDTH) bits), and a half-period counter that counts 0..HALF_PERIOD-1. Each wait below is exactly HALF_PERIOD cycles.
- **IDLE**
  - Outputs: SSEL=1, SCK=0, tx_ready=1.
  - On accept: load tx_data, latch tx_last, drive SSEL=0, drive MOSI=tx_data[WIDTH-1], clear bitcnt, go to LEAD.
- **LEAD**: wait, then drive SCK=1, shift MISO into rx register LSB (sampled on the same edge), go to HIGH.
- **HIGH**: wait, then drive SCK=0.
  - If bitcnt == WIDTH-1: load rx_data from the completed rx word, pulse rx_valid, go to WORD_END.
  - Otherwise: shift the tx register left, drive MOSI to the new MSB, increment bitcnt, go to LOW.
- **LOW**: wait, then drive SCK=1, sample MISO, go to HIGH.
- **WORD_END**: SCK=0, SSEL stays 0.
  - If the latched last flag is set: go to TRAIL (tx_ready=0).
  - Otherwise: tx_ready=1. Stay indefinitely until accept, then load as in IDLE and go to LEAD. SSEL is not toggled.
- **TRAIL**: wait, then drive SSEL=1, go to GUARD.
- **GUARD**: wait (minimum SSEL-high time), go to IDLE.
- tx_ready is combinational: (IDLE) or (WORD_END and not last). It is 0 while resetn is low.
- tx_valid when tx_ready=0 is ignored. tx_data/tx_last are sampled only on accept.
- MOSI holds its last value between words. After reset MOSI=0.
- Reset (any time, including mid-word): all outputs go immediately to SSEL=1, SCK=0, MOSI=0, rx_valid=0, rx_data=0, busy=0, state IDLE. A partially received word is discarded with no rx_valid.

## Timing
- H=HALF_PERIOD, W=WIDTH, t0 = accept edge. SSEL falls and the first MOSI bit are visible after t0.
- SCK rising edges occur at t0+H, t0+3H, … t0+(2W-1)H. Falling edges occur at t0+2H … t0+2W·H.
- MISO is sampled at each rising edge, so it must be stable ≥1 clk before it.
- MOSI changes only on falling edges or at accept, never within a high phase.
- rx_valid is high for exactly the cycle after edge t0+2W·H, with rx_data valid in that same cycle. W=8, H=4: 64 cycles.
- With last=1:
  - SSEL rises at t0+(2W+1)H.
  - tx_ready rises at t0+(2W+2)H (72 for defaults).
- With last=0: tx_ready is high from the rx_valid cycle onward.
  - If tx_valid is already high, the next word is accepted in that cycle. Its first rising edge follows H cycles later, so a single word period is 2W·H cycles.
- Single-word throughput: (2W+2)·H cycles per word.
- HALF_PERIOD=1 is legal: SCK toggles every clk.

## Test plan
- Loopback MOSI→MISO, send 0xA5 with last=1 → rx_valid once with rx_data=0xA5. SSEL low for exactly 17·4 cycles. 8 SCK pulses, each high 4 and low 4 cycles.
- MISO driven by a mode-0 slave model returning 0x3C while 0xC3 is sent → rx_data=0x3C. The model records MOSI=0xC3.
- Three words 0x01, 0x80, 0xFF: last=0, 0, 1, with tx_valid held → SSEL stays low throughout (no glitch). 24 SCK pulses. Three rx_valid pulses 64 cycles apart. SSEL rises 4 cycles after the third word.
- tx_valid pulsed with 0x55 during busy (LOW state) → not accepted, tx_ready=0. No extra transfer; the in-flight word completes unchanged.
- Reset asserted after the 4th SCK rising edge → SSEL=1, SCK=0, MOSI=0, busy=0 immediately. No rx_valid. After release a fresh 0x5A transfer completes correctly.
- HALF_PERIOD=1, WIDTH=16, loopback 0xBEEF → rx_data=0xBEEF, rx_valid 32 cycles after accept.
